// File: rtl/digi_ota_pkg.sv
// Shared types and helpers for the clocked digital OTA channel array.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents: channel FSM state enum, popcount used by the shared event
// counter, and a parameter-range predicate checked at elaboration.
package digi_ota_pkg;

  // Channel decision FSM: HOLD keeps the committed output, PEND is counting
  // consecutive qualifying cycles towards a new decision.
  typedef enum logic {
    HOLD = 1'b0,
    PEND = 1'b1
  } chan_state_e;

  localparam int MAX_CHANNELS = 8;
  localparam int MAX_DEBOUNCE = 15;

  // Number of set bits; sized for the widest legal channel count.
  function automatic logic [3:0] popcount(input logic [MAX_CHANNELS-1:0] bits);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      n = n + {3'b000, bits[i]};
    end
    return n;
  endfunction

  // True when every array parameter is inside its supported range.
  function automatic bit params_ok(input int channels,
                                   input int sync_stages,
                                   input int debounce,
                                   input int count_w);
    return (channels >= 1) && (channels <= MAX_CHANNELS) &&
           (sync_stages >= 2) &&
           (debounce >= 1) && (debounce <= MAX_DEBOUNCE) &&
           (count_w >= 1);
  endfunction

endpackage

// File: rtl/digi_ota_chan.sv
// One comparator channel: synchronise vip/vin, debounce, hold on common-mode.
// Latency: out_oe at SYNC_STAGES+1 edges, out/evt at SYNC_STAGES+DEBOUNCE (filtered) or SYNC_STAGES+1 (transparent).
// Backpressure: none; outputs are free-running registered levels and pulses.
//
// Ports: clk, rst_n (async, active-low), ena (freeze FSM when 0), mode
// (1 = transparent), vip/vin (asynchronous pad inputs), out (decision),
// out_oe (synchronised vip^vin), evt (one-cycle pulse when out changes).
module digi_ota_chan
  import digi_ota_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic mode,
  input  logic vip,
  input  logic vin,
  output logic out,
  output logic out_oe,
  output logic evt
);

  localparam int              CNT_W     = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single-cycle debounce the first qualifying cycle already commits.
  localparam bit              IMMEDIATE = (DEBOUNCE == 1);

  logic [SYNC_STAGES-1:0] vip_sync;
  logic [SYNC_STAGES-1:0] vin_sync;
  logic                   vip_s;
  logic                   vin_s;
  logic                   diff;
  logic                   qualify;

  chan_state_e            state;
  logic [CNT_W-1:0]       cnt;

  // Synchronisers keep running regardless of ena so out_oe stays live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vip_sync <= '0;
      vin_sync <= '0;
    end else begin
      vip_sync <= {vip_sync[SYNC_STAGES-2:0], vip};
      vin_sync <= {vin_sync[SYNC_STAGES-2:0], vin};
    end
  end

  assign vip_s = vip_sync[SYNC_STAGES-1];
  assign vin_s = vin_sync[SYNC_STAGES-1];
  assign diff  = vip_s ^ vin_s;

  // A cycle only counts towards a new decision when the pair is
  // differential and points away from the currently committed output.
  // Common-mode inputs never qualify, which is what latches out.
  assign qualify = ena && diff && (vip_s != out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HOLD;
      cnt    <= '0;
      out    <= 1'b0;
      out_oe <= 1'b0;
      evt    <= 1'b0;
    end else begin
      out_oe <= diff;
      evt    <= 1'b0;
      if (ena) begin
        case (state)
          HOLD: begin
            if (qualify) begin
              if (mode || IMMEDIATE) begin
                out <= vip_s;
                evt <= 1'b1;
              end else begin
                state <= PEND;
                cnt   <= CNT_ONE;
              end
            end
          end
          PEND: begin
            if (qualify) begin
              // Switching to transparent mode mid-count commits at once.
              if (mode || (cnt == CNT_LAST)) begin
                out   <= vip_s;
                evt   <= 1'b1;
                cnt   <= '0;
                state <= HOLD;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
              // Inputs went common-mode or fell back to out: drop the
              // pending decision.
              cnt   <= '0;
              state <= HOLD;
            end
          end
          default: begin
            cnt   <= '0;
            state <= HOLD;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/digi_ota_array.sv
// Multi-channel clocked digital OTA with a shared wrapping event counter.
// Latency: per-channel as digi_ota_chan; evt_total follows an evt pulse by one edge.
// Backpressure: none; outputs are free-running registered levels and pulses.
//
// Ports: clk, rst_n (async, active-low), ena (freeze channel FSMs and the
// counter), mode (1 = transparent), clr (synchronous clear of evt_total,
// beats same-cycle events), vip/vin[CHANNELS] (asynchronous pad inputs),
// out/out_oe/evt[CHANNELS] (per-channel outputs), evt_total[COUNT_W].
module digi_ota_array
  import digi_ota_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 3,
  parameter int COUNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                mode,
  input  logic                clr,
  input  logic [CHANNELS-1:0] vip,
  input  logic [CHANNELS-1:0] vin,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] out_oe,
  output logic [CHANNELS-1:0] evt,
  output logic [COUNT_W-1:0]  evt_total
);

  if (!params_ok(CHANNELS, SYNC_STAGES, DEBOUNCE, COUNT_W)) begin : g_bad_params
    $error("digi_ota_array: parameter out of supported range");
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    digi_ota_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .mode   (mode),
      .vip    (vip[ch]),
      .vin    (vin[ch]),
      .out    (out[ch]),
      .out_oe (out_oe[ch]),
      .evt    (evt[ch])
    );
  end

  logic [MAX_CHANNELS-1:0] evt_wide;
  logic [COUNT_W-1:0]      evt_inc;

  assign evt_wide = MAX_CHANNELS'(evt);
  // Narrow counters simply keep the low bits: the count wraps either way.
  assign evt_inc  = COUNT_W'(popcount(evt_wide));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_total <= '0;
    end else if (clr) begin
      evt_total <= '0;
    end else if (ena) begin
      evt_total <= evt_total + evt_inc;
    end
  end

endmodule
